// File: rtl/kt_cmd_pkg.sv
// Purpose: shared state/mode enums and response codes for the command arbiter.
// Latency: none (types and constants only).
// Backpressure: n/a.
package kt_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_RESP = 2'd2,
        HOLD      = 2'd3
    } arb_state_t;

    typedef enum logic {
        PRIORITY    = 1'b0,
        ROUND_ROBIN = 1'b1
    } arb_mode_t;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: pick one requesting source, fixed priority or round-robin from last winner+1.
// Latency: combinational winner; pointer updates on the cycle the winner is accepted.
// Backpressure: pointer only moves when advance is asserted, so an unaccepted pick is re-evaluated.
module rr_arbiter
    import kt_cmd_pkg::*;
#(
    parameter int        NUM_SRC  = 2,
    parameter arb_mode_t ARB_MODE = PRIORITY,
    localparam int       IDX_W    = $clog2(NUM_SRC)
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic               advance,
    output logic               win_vld,
    output logic [IDX_W-1:0]   win_idx
);

    logic [IDX_W-1:0] last_idx;
    int               cand;

    // Scan sources starting after the last winner (or at 0 in priority mode); first hit wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (ARB_MODE == ROUND_ROBIN) begin
                cand = int'(last_idx) + k;
                if (cand >= NUM_SRC) begin
                    cand = cand - NUM_SRC;
                end
            end else begin
                cand = k - 1;
            end
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end

    // Remember the accepted winner; reset value makes source 0 the first round-robin pick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_idx <= IDX_W'(NUM_SRC - 1);
        end else if (advance && win_vld) begin
            last_idx <= win_idx;
        end
    end

endmodule

// File: rtl/cmd_arbiter.sv
// Purpose: multiplex several command sources onto one cmd_proc, owning it until the sequence ends.
// Latency: grant/cmd/cmd_rdy one cycle after a ready source is seen in IDLE or HOLD.
// Backpressure: cmd held stable until clr_cmd_rdy; watchdog forces release after TIMEOUT_CYC cycles.
module cmd_arbiter
    import kt_cmd_pkg::*;
#(
    parameter int          NUM_SRC     = 2,
    parameter int          CMD_W       = 16,
    parameter arb_mode_t   ARB_MODE    = PRIORITY,
    parameter int unsigned TIMEOUT_CYC = 32'd1 << 20
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*CMD_W-1:0] src_cmd,
    input  logic [NUM_SRC-1:0]       src_cmd_rdy,
    input  logic [NUM_SRC-1:0]       src_last,
    output logic [NUM_SRC-1:0]       src_clr,
    output logic [CMD_W-1:0]         cmd,
    output logic                     cmd_rdy,
    input  logic                     clr_cmd_rdy,
    input  logic                     send_resp,
    output logic [7:0]               resp,
    output logic [NUM_SRC-1:0]       resp_src,
    output logic [NUM_SRC-1:0]       grant,
    output logic                     timeout
);

    localparam int          IDX_W    = $clog2(NUM_SRC);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

    arb_state_t         state, state_d;
    logic [CMD_W-1:0]   cmd_d;
    logic               cmd_rdy_d;
    logic               last_q, last_d;
    logic [7:0]         resp_d;
    logic [NUM_SRC-1:0] grant_d, src_clr_d, resp_src_d;
    logic [IDX_W-1:0]   own_idx, own_idx_d;
    logic               timeout_d;
    logic [31:0]        tmo_cnt, tmo_cnt_d;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic               arb_advance;
    logic               do_resp, do_tmo;

    rr_arbiter #(
        .NUM_SRC  (NUM_SRC),
        .ARB_MODE (ARB_MODE)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (src_cmd_rdy),
        .advance (arb_advance),
        .win_vld (win_vld),
        .win_idx (win_idx)
    );

    // Next-state and output decode; response and forced release are applied after the case.
    always_comb begin
        state_d     = state;
        cmd_d       = cmd;
        cmd_rdy_d   = cmd_rdy;
        last_d      = last_q;
        resp_d      = resp;
        grant_d     = grant;
        own_idx_d   = own_idx;
        src_clr_d   = '0;
        resp_src_d  = '0;
        timeout_d   = 1'b0;
        tmo_cnt_d   = tmo_cnt;
        arb_advance = 1'b0;
        do_resp     = 1'b0;
        do_tmo      = 1'b0;

        case (state)
            IDLE: begin
                if (win_vld) begin
                    arb_advance       = 1'b1;
                    own_idx_d         = win_idx;
                    grant_d           = '0;
                    grant_d[win_idx]  = 1'b1;
                    cmd_d             = src_cmd[win_idx*CMD_W +: CMD_W];
                    last_d            = src_last[win_idx];
                    cmd_rdy_d         = 1'b1;
                    state_d           = GRANT;
                end
            end
            GRANT: begin
                if (clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    src_clr_d = grant;
                    if (send_resp) begin
                        do_resp = 1'b1;
                    end else begin
                        state_d   = WAIT_RESP;
                        tmo_cnt_d = '0;
                    end
                end
            end
            WAIT_RESP: begin
                if (send_resp) begin
                    do_resp = 1'b1;
                end else if (tmo_cnt == TMO_LAST) begin
                    do_tmo = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt + 32'd1;
                end
            end
            HOLD: begin
                // Only the owning source may continue; everyone else waits for IDLE.
                if (src_cmd_rdy[own_idx]) begin
                    cmd_d     = src_cmd[own_idx*CMD_W +: CMD_W];
                    last_d    = src_last[own_idx];
                    cmd_rdy_d = 1'b1;
                    state_d   = GRANT;
                end else if (tmo_cnt == TMO_LAST) begin
                    do_tmo = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_resp) begin
            resp_d     = last_q ? RESP_DONE : RESP_BUSY;
            resp_src_d = grant;
            tmo_cnt_d  = '0;
            if (last_q) begin
                state_d = IDLE;
                grant_d = '0;
            end else begin
                state_d = HOLD;
            end
        end

        if (do_tmo) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
            grant_d   = '0;
        end
    end

    // State and registered outputs; reset abandons any transaction silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd      <= '0;
            cmd_rdy  <= 1'b0;
            last_q   <= 1'b0;
            resp     <= '0;
            grant    <= '0;
            own_idx  <= '0;
            src_clr  <= '0;
            resp_src <= '0;
            timeout  <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_d;
            cmd      <= cmd_d;
            cmd_rdy  <= cmd_rdy_d;
            last_q   <= last_d;
            resp     <= resp_d;
            grant    <= grant_d;
            own_idx  <= own_idx_d;
            src_clr  <= src_clr_d;
            resp_src <= resp_src_d;
            timeout  <= timeout_d;
            tmo_cnt  <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Purpose: check a 2-source priority arbiter and a 3-source round-robin arbiter against a model.
// Latency: model outputs are compared every falling edge.
// Backpressure: clr/send_resp driven randomly, including outside the states that honour them.
module tb_cmd_arbiter;

    localparam int TMO = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] sc;
    logic [2:0]  rdy, lst;
    logic        clr, snd;

    logic [1:0]  clr_a, rsrc_a, grant_a;
    logic [15:0] cmd_a;
    logic        cmd_rdy_a, tmo_a;
    logic [7:0]  resp_a;

    logic [2:0]  clr_b, rsrc_b, grant_b;
    logic [15:0] cmd_b;
    logic        cmd_rdy_b, tmo_b;
    logic [7:0]  resp_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cmd_arbiter #(.NUM_SRC(2), .CMD_W(16), .ARB_MODE(kt_cmd_pkg::PRIORITY), .TIMEOUT_CYC(TMO)) dut_a (
        .clk(clk), .rst_n(rst_n), .src_cmd(sc[31:0]), .src_cmd_rdy(rdy[1:0]), .src_last(lst[1:0]),
        .src_clr(clr_a), .cmd(cmd_a), .cmd_rdy(cmd_rdy_a), .clr_cmd_rdy(clr), .send_resp(snd),
        .resp(resp_a), .resp_src(rsrc_a), .grant(grant_a), .timeout(tmo_a));

    cmd_arbiter #(.NUM_SRC(3), .CMD_W(16), .ARB_MODE(kt_cmd_pkg::ROUND_ROBIN), .TIMEOUT_CYC(TMO)) dut_b (
        .clk(clk), .rst_n(rst_n), .src_cmd(sc), .src_cmd_rdy(rdy), .src_last(lst),
        .src_clr(clr_b), .cmd(cmd_b), .cmd_rdy(cmd_rdy_b), .clr_cmd_rdy(clr), .send_resp(snd),
        .resp(resp_b), .resp_src(rsrc_b), .grant(grant_b), .timeout(tmo_b));

    // Transaction-level view: who owns cmd_proc, what phase the exchange is in, and pending pulses.
    // phase: 0 free, 1 command offered, 2 awaiting response, 3 owner holding between commands.
    typedef struct {
        int          owner;
        int          phase;
        logic [15:0] cmd;
        bit          last;
        int          cnt;
        int          ptr;
        bit          cmd_rdy;
        logic [7:0]  resp;
        int          clr_to;
        int          resp_to;
        bit          tmo;
    } mdl_t;

    function automatic mdl_t mreset(int ns);
        mdl_t m;
        m.owner = -1; m.phase = 0; m.cmd = '0; m.last = 0; m.cnt = 0; m.ptr = ns - 1;
        m.cmd_rdy = 0; m.resp = '0; m.clr_to = -1; m.resp_to = -1; m.tmo = 0;
        return m;
    endfunction

    function automatic mdl_t step(mdl_t m, int ns, bit rr, logic [47:0] c_in, logic [2:0] r,
                                  logic [2:0] l, logic cl, logic sn);
        mdl_t n;
        int   best, bkey, key;
        bit   fire, expire;
        n = m; n.clr_to = -1; n.resp_to = -1; n.tmo = 0;
        fire = 0; expire = 0; best = -1; bkey = ns;
        if (m.phase == 0) begin
            // Winner = ready source at the smallest distance from the search start.
            for (int c = 0; c < ns; c++) begin
                key = rr ? (c - m.ptr - 1 + 2 * ns) % ns : c;
                if (r[c] && key < bkey) begin bkey = key; best = c; end
            end
            if (best >= 0) begin
                n.owner = best; n.ptr = best; n.phase = 1; n.cmd_rdy = 1;
                n.cmd = c_in[best*16 +: 16]; n.last = l[best];
            end
        end else if (m.phase == 1) begin
            if (cl) begin
                n.cmd_rdy = 0; n.clr_to = m.owner;
                if (sn) fire = 1;
                else begin n.phase = 2; n.cnt = 0; end
            end
        end else begin
            if (m.phase == 2 && sn) fire = 1;
            else if (m.phase == 3 && r[m.owner]) begin
                n.phase = 1; n.cmd_rdy = 1; n.cmd = c_in[m.owner*16 +: 16]; n.last = l[m.owner];
            end
            else if (m.cnt == TMO - 1) expire = 1;
            else n.cnt = m.cnt + 1;
        end
        if (fire) begin
            n.resp = m.last ? 8'hA5 : 8'h5A;
            n.resp_to = m.owner; n.cnt = 0;
            if (m.last) begin n.owner = -1; n.phase = 0; end
            else n.phase = 3;
        end
        if (expire) begin n.tmo = 1; n.owner = -1; n.phase = 0; end
        return n;
    endfunction

    function automatic logic [2:0] oh(int i);
        if (i < 0) return 3'b000;
        return 3'b001 << i;
    endfunction

    mdl_t ma = mreset(2);
    mdl_t mb = mreset(3);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = mreset(2);
            mb = mreset(3);
        end else begin
            ma = step(ma, 2, 1'b0, sc, rdy & 3'b011, lst, clr, snd);
            mb = step(mb, 3, 1'b1, sc, rdy, lst, clr, snd);
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        chk("A.grant",    32'(grant_a),   32'(oh(ma.owner)));
        chk("A.cmd_rdy",  32'(cmd_rdy_a), 32'(ma.cmd_rdy));
        chk("A.resp",     32'(resp_a),    32'(ma.resp));
        chk("A.src_clr",  32'(clr_a),     32'(oh(ma.clr_to)));
        chk("A.resp_src", 32'(rsrc_a),    32'(oh(ma.resp_to)));
        chk("A.timeout",  32'(tmo_a),     32'(ma.tmo));
        if (ma.cmd_rdy) chk("A.cmd", 32'(cmd_a), 32'(ma.cmd));
        chk("B.grant",    32'(grant_b),   32'(oh(mb.owner)));
        chk("B.cmd_rdy",  32'(cmd_rdy_b), 32'(mb.cmd_rdy));
        chk("B.resp",     32'(resp_b),    32'(mb.resp));
        chk("B.src_clr",  32'(clr_b),     32'(oh(mb.clr_to)));
        chk("B.resp_src", 32'(rsrc_b),    32'(oh(mb.resp_to)));
        chk("B.timeout",  32'(tmo_b),     32'(mb.tmo));
        if (mb.cmd_rdy) chk("B.cmd", 32'(cmd_b), 32'(mb.cmd));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int grant_exp [4] = '{1, 2, 4, 1};

    initial begin
        sc = {16'h9ABC, 16'h5678, 16'h1234};
        rdy = '0; lst = '0; clr = 0; snd = 0;
        tick();
        chk("rst.grant", 32'(grant_a), 0);
        chk("rst.cmd", 32'(cmd_a), 0);
        chk("rst.resp", 32'(resp_b), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Priority: both ready, source 0 first, then source 1.
        rdy = 3'b011; lst = 3'b011;
        tick();
        chk("p.grant0", 32'(grant_a), 32'h1);
        chk("p.cmd0", 32'(cmd_a), 32'h1234);
        chk("p.cmd_rdy0", 32'(cmd_rdy_a), 32'h1);
        clr = 1; rdy = 3'b010;
        tick();
        chk("p.src_clr0", 32'(clr_a), 32'h1);
        chk("p.cmd_rdy_drop", 32'(cmd_rdy_a), 32'h0);
        clr = 0; snd = 1;
        tick();
        chk("p.resp0", 32'(resp_a), 32'hA5);
        chk("p.resp_src0", 32'(rsrc_a), 32'h1);
        snd = 0;
        tick();
        chk("p.grant1", 32'(grant_a), 32'h2);
        chk("p.cmd1", 32'(cmd_a), 32'h5678);

        // Same-cycle clear and response.
        rdy = 3'b000; clr = 1; snd = 1;
        tick();
        chk("s.src_clr", 32'(clr_a), 32'h2);
        chk("s.resp_src", 32'(rsrc_a), 32'h2);
        chk("s.grant", 32'(grant_a), 32'h0);
        clr = 0; snd = 0;
        tick();

        // Multi-command sequence from source 1 while source 0 waits.
        rdy = 3'b010; lst = 3'b000;
        tick();
        chk("m.grant", 32'(grant_a), 32'h2);
        rdy = 3'b011;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) lst = 3'b010;
            if (i > 0) begin
                tick();
                chk("m.regrant", 32'(grant_a), 32'h2);
                chk("m.cmd_rdy", 32'(cmd_rdy_a), 32'h1);
            end
            clr = 1; snd = 1;
            tick();
            chk("m.resp", 32'(resp_a), (i == 2) ? 32'hA5 : 32'h5A);
            chk("m.resp_src", 32'(rsrc_a), 32'h2);
            clr = 0; snd = 0;
        end
        tick();
        chk("m.next_src0", 32'(grant_a), 32'h1);

        // Watchdog: cleared but never answered.
        rdy = 3'b000; clr = 1;
        tick();
        clr = 0;
        for (int i = 1; i < TMO; i++) begin
            tick();
            chk("t.early", 32'(tmo_a), 32'h0);
        end
        tick();
        chk("t.pulse", 32'(tmo_a), 32'h1);
        chk("t.grant", 32'(grant_a), 32'h0);
        chk("t.resp_src", 32'(rsrc_a), 32'h0);
        chk("t.resp_kept", 32'(resp_a), 32'hA5);
        tick();
        chk("t.one_cycle", 32'(tmo_a), 32'h0);

        // Reset while waiting for a response.
        rdy = 3'b001; lst = 3'b001;
        tick();
        rdy = 3'b000; clr = 1;
        tick();
        clr = 0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("r.grant_a", 32'(grant_a), 32'h0);
        chk("r.grant_b", 32'(grant_b), 32'h0);
        chk("r.cmd_rdy", 32'(cmd_rdy_a), 32'h0);
        chk("r.resp", 32'(resp_a), 32'h0);
        tick();
        chk("r.src_clr", 32'(clr_a), 32'h0);
        chk("r.resp_src", 32'(rsrc_a), 32'h0);
        rdy = 3'b111; lst = 3'b111;
        rst_n = 1'b1;

        // Round-robin with everyone ready: 0,1,2,0.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr.grant", 32'(grant_b), 32'(grant_exp[i]));
            clr = 1; snd = 1;
            tick();
            clr = 0; snd = 0;
        end

        // Random traffic; last stretch never answers so the watchdog fires.
        for (int i = 0; i < 3000; i++) begin
            sc  = {16'($urandom), 16'($urandom), 16'($urandom)};
            rdy = 3'($urandom);
            lst = 3'($urandom);
            clr = ($urandom_range(0, 1) == 1);
            snd = (i >= 2000) ? 1'b0 : ($urandom_range(0, 2) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1; clr = 0; snd = 0; rdy = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
